// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_pkg
// Description : Shared CPU defines: fetch FSM encodings and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_fetch_pkg;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_RESET_PC = 0;

    localparam int                 STATE_W = 1;
    localparam logic [STATE_W-1:0] FETCH   = 1'b0;
    localparam logic [STATE_W-1:0] HOLD    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with reset, load (redirect) and wrapping +1.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_pc,
    input  logic             inc,
    output logic [WIDTH-1:0] pc
);

    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_pc;

    // Load beats increment so a redirect always wins over a completing fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (load) begin
            r_pc <= load_pc;
        end else if (inc) begin
            r_pc <= r_pc + C_ONE;
        end
    end

    assign pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Two-state instruction fetch unit (FETCH / HOLD) with redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic             clk,
    input  logic             reset,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] pc
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic [WIDTH-1:0]   r_instr;
    logic [WIDTH-1:0]   r_instr_pc;
    logic [WIDTH-1:0]   w_pc;
    logic               w_capture;

    // A returning word is only kept when no redirect is discarding it.
    assign w_capture = (r_state == FETCH) && mem_ack && !redirect;

    pc_reg #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .reset   (reset),
        .load    (redirect),
        .load_pc (redirect_pc),
        .inc     (w_capture),
        .pc      (w_pc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (redirect) begin
            w_next_state = FETCH;
        end else if (r_state == FETCH) begin
            if (mem_ack) begin
                w_next_state = HOLD;
            end
        end else if (instr_ready) begin
            w_next_state = FETCH;
        end
    end

    // Reset is folded in combinationally so no request or valid leaks out
    // during the reset cycle itself.
    always_comb begin
        mem_req     = 1'b0;
        instr_valid = 1'b0;
        if (!reset) begin
            mem_req     = (r_state == FETCH);
            instr_valid = (r_state == HOLD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= '0;
            r_instr_pc <= '0;
        end else if (w_capture) begin
            r_instr    <= mem_rdata;
            r_instr_pc <= w_pc;
        end
    end

    assign mem_addr = w_pc;
    assign pc       = w_pc;
    assign instr    = r_instr;
    assign instr_pc = r_instr_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Self-checking bench for instr_fetch: directed scenarios plus
//               randomized traffic against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    localparam int               WIDTH    = 16;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_ready;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] pc;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: "is an instruction waiting for decode", next address,
    // and the held instruction with its address.
    bit               m_have;
    logic [WIDTH-1:0] m_pc;
    logic [WIDTH-1:0] m_instr;
    logic [WIDTH-1:0] m_ipc;

    instr_fetch #(
        .WIDTH    (WIDTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock with the currently applied inputs, then
    // let the DUT take the same edge.
    task automatic tick();
        if (reset) begin
            m_have  = 1'b0;
            m_pc    = RESET_PC;
            m_instr = '0;
            m_ipc   = '0;
        end else if (redirect) begin
            m_have = 1'b0;
            m_pc   = redirect_pc;
        end else if (!m_have && mem_ack) begin
            m_instr = mem_rdata;
            m_ipc   = m_pc;
            m_pc    = m_pc + 16'd1;
            m_have  = 1'b1;
        end else if (m_have && instr_ready) begin
            m_have = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick();
        tick();
        n_cmp++;
        if (mem_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req);
        end
        n_cmp++;
        if (instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid);
        end
        n_cmp++;
        if (pc !== RESET_PC || instr !== 16'h0000 || instr_pc !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_regs: got pc=%h instr=%h ipc=%h want %h/0000/0000",
                     pc, instr, instr_pc, RESET_PC);
        end
        reset = 1'b0; mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL first_req: got req=%b addr=%h want 1/%h", mem_req, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        mem_ack = 1'b1; instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 16'hA000 + 16'(k);
            #1;
            n_cmp++;
            if (instr_valid !== 1'b0 || mem_addr !== 16'(k)) begin
                n_fail++;
                $display("FAIL zw_fetch%0d: got valid=%b addr=%h want 0/%h", k, instr_valid, mem_addr, 16'(k));
            end
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || instr !== 16'hA000 + 16'(k) || instr_pc !== 16'(k)
                || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL zw_hold%0d: got valid=%b instr=%h ipc=%h req=%b want 1/%h/%h/0",
                         k, instr_valid, instr, instr_pc, mem_req, 16'hA000 + 16'(k), 16'(k));
            end
            tick();
        end
    endtask

    task automatic test_ack_delay();
        mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== 16'h0004 || instr_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL delay_wait%0d: got req=%b addr=%h valid=%b want 1/0004/0",
                         k, mem_req, mem_addr, instr_valid);
            end
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0004) begin
            n_fail++;
            $display("FAIL delay_ack: got valid=%b instr=%h ipc=%h want 1/1234/0004",
                     instr_valid, instr, instr_pc);
        end
    endtask

    task automatic test_stall();
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr !== 16'h1234 || pc !== 16'h0005) begin
                n_fail++;
                $display("FAIL stall%0d: got valid=%b req=%b instr=%h pc=%h want 1/0/1234/0005",
                         k, instr_valid, mem_req, instr, pc);
            end
        end
        instr_ready = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0005) begin
            n_fail++;
            $display("FAIL stall_release: got req=%b addr=%h want 1/0005", mem_req, mem_addr);
        end
    endtask

    task automatic test_redirect_ack();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF; redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_addr !== 16'h0040 || mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL redir_ack_addr: got valid=%b addr=%h req=%b want 0/0040/1",
                     instr_valid, mem_addr, mem_req);
        end
        n_cmp++;
        if (instr !== 16'h1234 || instr_pc !== 16'h0004) begin
            n_fail++;
            $display("FAIL redir_ack_drop: got instr=%h ipc=%h want 1234/0004", instr, instr_pc);
        end
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || instr !== 16'h5555) begin
            n_fail++;
            $display("FAIL wrap_hold: got valid=%b ipc=%h instr=%h want 1/ffff/5555",
                     instr_valid, instr_pc, instr);
        end
        instr_ready = 1'b1;
        tick();
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_next: got req=%b addr=%h want 1/0000", mem_req, mem_addr);
        end
    endtask

    task automatic test_reset_in_hold();
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0; instr_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_hold_comb: got valid=%b req=%b want 0/0", instr_valid, mem_req);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_cmp++;
            if (instr_valid !== 1'b0 || mem_req !== 1'b0 || pc !== RESET_PC || instr !== 16'h0000) begin
                n_fail++;
                $display("FAIL rst_hold%0d: got valid=%b req=%b pc=%h instr=%h want 0/0/%h/0000",
                         k, instr_valid, mem_req, pc, instr, RESET_PC);
            end
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
            n_fail++;
            $display("FAIL rst_release: got req=%b addr=%h want 1/%h", mem_req, mem_addr, RESET_PC);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            reset       = ($urandom_range(0, 39) == 0);
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = 16'($urandom);
            mem_ack     = $urandom_range(0, 1) == 1;
            mem_rdata   = 16'($urandom);
            instr_ready = $urandom_range(0, 1) == 1;
            #1;
            n_cmp++;
            if (mem_req !== (!m_have && !reset) || instr_valid !== (m_have && !reset)
                || mem_addr !== m_pc || pc !== m_pc || instr !== m_instr || instr_pc !== m_ipc) begin
                n_fail++;
                $display("FAIL rand%0d: got req=%b valid=%b addr=%h pc=%h instr=%h ipc=%h want %b/%b/%h/%h/%h/%h",
                         k, mem_req, instr_valid, mem_addr, pc, instr, instr_pc,
                         !m_have && !reset, m_have && !reset, m_pc, m_pc, m_instr, m_ipc);
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_zero_wait();
        test_ack_delay();
        test_stall();
        test_redirect_ack();
        test_wrap();
        test_reset_in_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter SHALL be: WIDTH, 16, datapath/address width in bits.
REQ-002 Parameter SHALL be: RESET_PC, 0, PC value loaded on reset.
REQ-003 Port SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port SHALL be: reset  input  1  synchronous, active-high reset.
REQ-005 Port SHALL be: mem_req  output  1  instruction-memory read request.
REQ-006 Port SHALL be: mem_addr  output  WIDTH  word address of current request.
REQ-007 Port SHALL be: mem_ack  input  1  memory returns data this cycle; ignored when mem_req=0.
REQ-008 Port SHALL be: mem_rdata  input  WIDTH  read data, valid when mem_ack=1.
REQ-009 Port SHALL be: instr  output  WIDTH  held instruction word to decode.
REQ-010 Port SHALL be: instr_pc  output  WIDTH  address instr was fetched from.
REQ-011 Port SHALL be: instr_valid  output  1  instr/instr_pc valid for decode.
REQ-012 Port SHALL be: instr_ready  input  1  decode accepts instr this cycle.
REQ-013 Port SHALL be: redirect  input  1  branch/jump taken; discard and refetch.
REQ-014 Port SHALL be: redirect_pc  input  WIDTH  target address, sampled when redirect=1.
REQ-015 Port SHALL be: pc  output  WIDTH  next fetch address (feeds the PC-source select mux).

Function
REQ-016 Block SHALL implement a two-state FSM: FETCH, HOLD.
REQ-017 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc; instr_valid SHALL be 0.
REQ-018 In FETCH with mem_ack=1 and redirect=0: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1, state<=HOLD.
REQ-019 In FETCH with mem_ack=0, mem_addr and pc SHALL remain stable until ack or redirect.
REQ-020 In HOLD, mem_req SHALL be 0 and instr_valid SHALL be 1; instr/instr_pc SHALL remain stable.
REQ-021 In HOLD with instr_ready=1 and redirect=0, state<=FETCH; with instr_ready=0, remain HOLD.
REQ-022 Latency: mem_ack in cycle N SHALL produce instr_valid=1 in cycle N+1; zero-wait memory yields one instruction per 2 cycles.
REQ-023 pc+1 SHALL wrap modulo 2^WIDTH (16'hFFFF -> 16'h0000), no flag.
REQ-024 redirect=1 in any state SHALL: pc<=redirect_pc, state<=FETCH, instr_valid=0 next cycle.
REQ-025 redirect=1 coinciding with mem_ack=1 SHALL discard mem_rdata; instr/instr_pc unchanged.
REQ-026 redirect=1 coinciding with HOLD and instr_ready=1 SHALL still count as a handshake for decode, then refetch from redirect_pc.
REQ-027 Priority SHALL be reset > redirect > mem_ack/instr_ready.
REQ-028 After redirect in FETCH without ack, the next cycle's mem_addr SHALL be redirect_pc; the abandoned request is legal for memory.

Reset
REQ-029 While reset=1 at a rising edge: pc<=RESET_PC, state<=FETCH, instr<=0, instr_pc<=0.
REQ-030 mem_req and instr_valid SHALL be 0 in any cycle where reset=1, overriding the FSM.
REQ-031 Reset mid-fetch or mid-hold SHALL discard all in-flight data; mem_ack during reset is ignored.
REQ-032 First mem_req=1 with mem_addr=RESET_PC SHALL occur the first cycle after reset deasserts.

Structure
REQ-033 FSM state encodings (FETCH=0, HOLD=1) and default WIDTH/RESET_PC SHALL live in the shared CPU defines package.
REQ-034 PC register with increment/load/reset SHALL be a sub-module pc_reg (WIDTH, RESET_PC parameters).
REQ-035 Datapath output regs SHALL be plain flops without enables on mem_addr (combinational from pc).

Verification
REQ-036 Reset then zero-wait memory returning 16'hA000+addr, ready=1 -> instr 16'hA000 @pc 0, 16'hA001 @pc 1, valid every other cycle.
REQ-037 mem_ack delayed 3 cycles -> mem_addr stable 3 cycles, instr_valid rises cycle after ack.
REQ-038 instr_ready=0 for 4 cycles in HOLD -> instr stable, mem_req=0, no pc change.
REQ-039 redirect to 16'h0040 same cycle as mem_ack -> data dropped, next mem_addr=16'h0040, valid stays 0.
REQ-040 redirect_pc=16'hFFFF, ack -> instr_pc=16'hFFFF, next mem_addr=16'h0000.
REQ-041 reset asserted while in HOLD -> next cycle instr_valid=0, pc=RESET_PC, mem_req=0 until release.
